// File: rtl/joybus_device.sv
// JOYBUS controller-side responder: decodes a host command byte and answers poll/status on an open-drain line.
// Optional: JOYBUS_DEV_RESET_CMD_EN makes command 0xFF reply like the status command 0x00.
module joybus_device #(
    parameter int CLK_PER_US = 25,
    parameter int TIMEOUT_US = 8,
    parameter int TURN_US    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    inout  wire         io_jb,
    input  logic [15:0] i_btn,
    input  logic [7:0]  i_stick_x,
    input  logic [7:0]  i_stick_y,
    output logic        o_cmd_vld,
    output logic [7:0]  o_cmd,
    output logic        o_tx_active
);

    // state      | meaning
    // S_IDLE     | line idle, waiting for a host falling edge
    // S_RX_LOW   | measuring a host low pulse
    // S_RX_HIGH  | measuring the high gap between host bits
    // S_DECODE   | one cycle: pick reply and snapshot inputs
    // S_TURN     | gap between host stop bit and first reply bit
    // S_TX_BIT   | sending one reply bit
    // S_TX_STOP  | sending the reply stop bit and trailing release
    typedef enum logic [2:0] {
        S_IDLE, S_RX_LOW, S_RX_HIGH, S_DECODE, S_TURN, S_TX_BIT, S_TX_STOP
    } state_t;

    localparam int CW   = 12;
    localparam int BIT  = 4 * CLK_PER_US;
    localparam int SHRT = 1 * CLK_PER_US;
    localparam int LNG  = 3 * CLK_PER_US;
    localparam int STP  = 2 * CLK_PER_US;

    localparam logic [CW-1:0] C_ONE       = 1;
    localparam logic [CW-1:0] C_THRESH    = CW'(2 * CLK_PER_US);
    localparam logic [CW-1:0] C_TMO       = CW'(TIMEOUT_US * CLK_PER_US);
    localparam logic [CW-1:0] C_TURN_LD   = CW'(TURN_US * CLK_PER_US - 2);
    localparam logic [CW-1:0] C_BIT_M1    = CW'(BIT - 1);
    localparam logic [CW-1:0] C_SHORT_REL = CW'(BIT - SHRT);
    localparam logic [CW-1:0] C_LONG_REL  = CW'(BIT - LNG);
    localparam logic [CW-1:0] C_STOP_M1   = CW'(STP + BIT - 1);
    localparam logic [CW-1:0] C_STOP_REL  = CW'(BIT);

    state_t         r_state;
    logic [1:0]     r_sync;
    logic           r_jb_d;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_tmr;
    logic [3:0]     r_nbits;
    logic [7:0]     r_shreg;
    logic [31:0]    r_tx_sh;
    logic [4:0]     r_tx_left;
    logic           r_drive;
    logic           r_cmd_vld;
    logic [7:0]     r_cmd;
    logic           r_tx_active;

    logic w_jb_s;
    logic w_fall;
    logic w_rise;
    logic w_poll;
    logic w_status;

    assign io_jb  = r_drive ? 1'b0 : 1'bz;
    assign w_jb_s = r_sync[1];
    // Own drive echoes back through the synchronizer; mask it while we own the line.
    assign w_fall = r_jb_d & ~w_jb_s & ~r_tx_active;
    assign w_rise = ~r_jb_d & w_jb_s & ~r_tx_active;
    assign w_poll = (r_shreg == 8'h01);
`ifdef JOYBUS_DEV_RESET_CMD_EN
    assign w_status = (r_shreg == 8'h00) || (r_shreg == 8'hFF);
`else
    assign w_status = (r_shreg == 8'h00);
`endif

    assign o_cmd_vld   = r_cmd_vld;
    assign o_cmd       = r_cmd;
    assign o_tx_active = r_tx_active;

    // Sync flops reset high so a released line is not seen as a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_jb_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], io_jb};
            r_jb_d <= w_jb_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_nbits     <= '0;
            r_shreg     <= '0;
            r_tx_sh     <= '0;
            r_tx_left   <= '0;
            r_drive     <= 1'b0;
            r_cmd_vld   <= 1'b0;
            r_cmd       <= '0;
            r_tx_active <= 1'b0;
        end else begin
            r_cmd_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_RX_LOW;
                        r_cnt   <= C_ONE;
                        r_nbits <= '0;
                    end
                end
                S_RX_LOW: begin
                    if (w_rise) begin
                        r_cnt <= C_ONE;
                        if (r_nbits == 4'd8) begin
                            r_cmd_vld   <= 1'b1;
                            r_cmd       <= r_shreg;
                            r_tx_active <= w_poll | w_status;
                            r_state     <= S_DECODE;
                        end else begin
                            r_shreg <= {r_shreg[6:0], (r_cnt < C_THRESH)};
                            r_nbits <= r_nbits + 4'd1;
                            r_state <= S_RX_HIGH;
                        end
                    end else if (r_cnt == C_TMO) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_RX_HIGH: begin
                    if (w_fall) begin
                        r_cnt   <= C_ONE;
                        r_state <= S_RX_LOW;
                    end else if (r_cnt == C_TMO) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_DECODE: begin
                    r_cnt <= '0;
                    r_tmr <= C_TURN_LD;
                    if (w_poll) begin
                        r_tx_sh   <= {i_btn, i_stick_x, i_stick_y};
                        r_tx_left <= 5'd31;
                        r_state   <= S_TURN;
                    end else if (w_status) begin
                        r_tx_sh   <= 32'h0500_0200;
                        r_tx_left <= 5'd23;
                        r_state   <= S_TURN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TURN: begin
                    if (r_tmr == '0) begin
                        r_state <= S_TX_BIT;
                        r_tmr   <= C_BIT_M1;
                        r_drive <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - C_ONE;
                    end
                end
                S_TX_BIT: begin
                    if (r_tmr == '0) begin
                        r_drive <= 1'b1;
                        if (r_tx_left != 5'd0) begin
                            r_tx_sh   <= {r_tx_sh[30:0], 1'b0};
                            r_tx_left <= r_tx_left - 5'd1;
                            r_tmr     <= C_BIT_M1;
                        end else begin
                            r_state <= S_TX_STOP;
                            r_tmr   <= C_STOP_M1;
                        end
                    end else begin
                        r_tmr   <= r_tmr - C_ONE;
                        r_drive <= r_tx_sh[31] ? (r_tmr > C_SHORT_REL) : (r_tmr > C_LONG_REL);
                    end
                end
                S_TX_STOP: begin
                    if (r_tmr == '0) begin
                        r_state     <= S_IDLE;
                        r_drive     <= 1'b0;
                        r_tx_active <= 1'b0;
                    end else begin
                        r_tmr   <= r_tmr - C_ONE;
                        r_drive <= (r_tmr > C_STOP_REL);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_drive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_device.sv
// Bench for joybus_device: host model sends command frames, a line decoder checks replies against a scoreboard.
module tb_joybus_device;

    localparam int CPU     = 25;
    localparam int TURN_CY = 2 * CPU;
    localparam int BIT_CY  = 4 * CPU;

    typedef struct {
        logic [31:0] data;
        int          len;
    } rep_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_low = 1'b0;
    logic [15:0] btn = '0;
    logic [7:0]  stick_x = '0;
    logic [7:0]  stick_y = '0;
    logic        cmd_vld;
    logic [7:0]  cmd;
    logic        tx_active;
    wire         jb;

    pullup (jb);
    assign jb = host_low ? 1'b0 : 1'bz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cyc_vld = 0;
    logic [31:0] last_reply = '0;

    logic [7:0] cmd_q[$];
    rep_t       exp_q[$];

    joybus_device #(.CLK_PER_US(CPU), .TIMEOUT_US(8), .TURN_US(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_jb       (jb),
        .i_btn       (btn),
        .i_stick_x   (stick_x),
        .i_stick_y   (stick_y),
        .o_cmd_vld   (cmd_vld),
        .o_cmd       (cmd),
        .o_tx_active (tx_active)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Command monitor: every cmd_vld must match the next queued command.
    always @(negedge clk) begin
        if (!rst && cmd_vld) begin
            cyc_vld = cyc;
            if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(cmd), 32'hFFFF_FFFF);
            else chk("cmd", 32'(cmd), 32'(cmd_q.pop_front()));
        end
    end

    // Reply decoder: measures low pulses driven by the DUT on the line.
    int          d_run = 0;
    int          d_nb = 0;
    int          d_last = 0;
    logic        d_prev = 1'b0;
    logic        d_in = 1'b0;
    logic [31:0] d_acc = '0;
    always @(negedge clk) begin
        logic w;
        rep_t e;
        w = (jb === 1'b0) && !host_low;
        if (rst) begin
            d_run = 0; d_nb = 0; d_prev = 1'b0; d_in = 1'b0; d_acc = '0;
        end else begin
            if (w && !d_prev) begin
                if (!d_in) begin
                    d_in = 1'b1; d_nb = 0; d_acc = '0;
                    if (exp_q.size() == 0) chk("reply_unexpected", 32'd1, 32'd0);
                    else chk("latency", 32'(cyc - cyc_vld), 32'(TURN_CY));
                end else begin
                    chk("bit_period", 32'(cyc - d_last), 32'(BIT_CY));
                end
                chk("txact_drive", 32'(tx_active), 32'd1);
                d_last = cyc;
                d_run  = 0;
            end
            if (w) d_run++;
            if (!w && d_prev) begin
                if (d_run == CPU || d_run == 3 * CPU) begin
                    d_acc = {d_acc[30:0], (d_run == CPU)};
                    d_nb++;
                end else if (d_run == 2 * CPU) begin
                    chk("txact_stop", 32'(tx_active), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("reply_len", 32'(d_nb), 32'(e.len));
                        chk("reply_data", d_acc, e.data);
                    end
                    last_reply = d_acc;
                    d_in = 1'b0;
                end else begin
                    chk("pulse_width", 32'(d_run), 32'(CPU));
                end
            end
            d_prev = w;
        end
    end

    task automatic send_bit(input logic b);
        host_low = 1'b1;
        repeat (b ? CPU : 3 * CPU) @(negedge clk);
        host_low = 1'b0;
        repeat (b ? 3 * CPU : CPU) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        host_low = 1'b1;
        repeat (CPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] c, input logic [31:0] d, input int len);
        rep_t e;
        cmd_q.push_back(c);
        if (len > 0) begin
            e.data = d;
            e.len  = len;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_reply(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk(tag, 32'd0, 32'd1);
        repeat (50) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (5) @(negedge clk);
        chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_tx_active", 32'(tx_active), 32'd0);
        chk("rst_jb", 32'(jb), 32'd1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Poll; button word drops mid-reply, the snapshot must hold.
        btn = 16'h8000; stick_x = 8'h7F; stick_y = 8'h81;
        expect_frame(8'h01, 32'h8000_7F81, 32);
        send_byte(8'h01);
        repeat (400) @(negedge clk);
        btn = 16'h0000;
        wait_reply("poll_timeout", 6000);
        chk("btn_A", 32'(last_reply[31]), 32'd1);
        chk("poll_txact_end", 32'(tx_active), 32'd0);

        // Status.
        expect_frame(8'h00, 32'h0005_0002, 24);
        send_byte(8'h00);
        wait_reply("status_timeout", 6000);
        chk("status_txact_end", 32'(tx_active), 32'd0);

        // Unknown command: no reply.
        expect_frame(8'h42, 32'h0, 0);
        send_byte(8'h42);
        repeat (4000) @(negedge clk);
        chk("unknown_txact", 32'(tx_active), 32'd0);
        chk("unknown_cmd_hold", 32'(cmd), 32'h42);
        chk("unknown_queue", 32'(cmd_q.size()), 32'd0);

        // Truncated frame: 4 bits then 10 us high.
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        repeat (10 * CPU) @(negedge clk);
        chk("trunc_cmd_hold", 32'(cmd), 32'h42);
        chk("trunc_txact", 32'(tx_active), 32'd0);

        btn = 16'h1234; stick_x = 8'h80; stick_y = 8'h05;
        expect_frame(8'h01, 32'h1234_8005, 32);
        send_byte(8'h01);
        wait_reply("poll2_timeout", 6000);

        // 0xFF: status reply only when the reset-command option is built in.
`ifdef JOYBUS_DEV_RESET_CMD_EN
        expect_frame(8'hFF, 32'h0005_0002, 24);
        send_byte(8'hFF);
        wait_reply("ff_timeout", 6000);
`else
        expect_frame(8'hFF, 32'h0, 0);
        send_byte(8'hFF);
        repeat (4000) @(negedge clk);
        chk("ff_txact", 32'(tx_active), 32'd0);
`endif

        // Reset while the DUT holds the line low mid-reply.
        expect_frame(8'h00, 32'h0005_0002, 24);
        send_byte(8'h00);
        repeat (560) @(negedge clk);
        n = 0;
        while (!(jb === 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("midtx_found_drive", 32'(jb === 1'b0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midtx_rst_jb", 32'(jb), 32'd1);
        chk("midtx_rst_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("midtx_rst_cmd", 32'(cmd), 32'd0);
        chk("midtx_rst_txact", 32'(tx_active), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_rst_jb", 32'(jb), 32'd1);

        // Recovery after reset.
        expect_frame(8'h00, 32'h0005_0002, 24);
        send_byte(8'h00);
        wait_reply("recover_timeout", 6000);
        chk("final_cmd_queue", 32'(cmd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/joybus_device.md
# joybus_device

Controller-side JOYBUS responder: emulates an N64 controller on the single-wire bus. It decodes the 8-bit command sent by a console or host, then replies with status or button/stick data on the same wire. It sits beside the host poller in the N64-GC-FPGA design, and lets the host be tested against an on-chip controller or lets the FPGA stand in for a real pad. The line is driven open-drain: the block drives 0 or releases to high-Z.

## Interface
- CLK_PER_US, 25, clock cycles per microsecond (25 MHz system clock)
- TIMEOUT_US, 8, maximum idle-high or stuck-low time inside a frame before abort
- TURN_US, 2, gap from the host stop-bit rising edge to the first reply bit
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- JB  inout  1  bus line; driven 0 or z only
- btn  in  16  button word, bit 15 = A … bit 0 = C-right (N64 order: A B Z S Du Dd Dl Dr 0 0 L R Cu Cd Cl Cr)
- stick_x  in  8  signed stick X, two's complement, passed through unchanged
- stick_y  in  8  signed stick Y
- cmd_vld  out  1  one-cycle pulse when a complete command byte plus stop bit is decoded
- cmd  out  8  last decoded command byte, held until the next cmd_vld
- tx_active  out  1  high while the block owns the line (TURNAROUND through TX_STOP)

## Operation
- JB input passes through a 2-flop synchronizer, giving jb_s; a falling or rising edge is detected on jb_s.
- Bit times: BIT = 4·CLK_PER_US, SHORT = 1·CLK_PER_US, LONG = 3·CLK_PER_US.
- States:
  - IDLE: a falling edge on jb_s moves to RX_LOW.
  - RX_LOW: counts low cycles.
    - On a rising edge, the bit is 0 if the count is ≥ 2·CLK_PER_US, else 1. The bit shifts into shreg MSB-first and the state moves to RX_HIGH.
    - If the low count reaches TIMEOUT, the frame aborts to IDLE.
  - RX_HIGH: counts high cycles.
    - Fewer than 8 bits received: a falling edge returns to RX_LOW. High count reaching TIMEOUT aborts to IDLE with no cmd_vld.
    - 8 bits received: the next low pulse is the stop bit, and its width is not decoded. On the stop rising edge, cmd_vld pulses, cmd is loaded, and the state moves to DECODE.
- DECODE (1 cycle):
  - 0x01: snapshot {btn, stick_x, stick_y} into a 32-bit tx register; length 32.
  - 0x00: tx = 0x050002 left-aligned; length 24.
  - Other bytes: no reply; return to IDLE.
- TURNAROUND: wait TURN_US·CLK_PER_US cycles after the stop edge (the DECODE cycle is included in the count), then TX_BIT.
- TX_BIT: each bit lasts BIT cycles, MSB first.
  - A 1 drives 0 for SHORT cycles, then releases.
  - A 0 drives 0 for LONG cycles, then releases.
  - After the last bit, move to TX_STOP.
- TX_STOP: drive 0 for 2·CLK_PER_US, then release for one full BIT, then IDLE.
- RX edge detection is ignored while tx_active is high, so the block's own drive is never decoded.
- Inputs are sampled only at DECODE; changes during TX do not alter the reply.

## Timing
- Reset (rst high at a clk edge): JB released on the next cycle, state = IDLE, cmd_vld = 0, cmd = 0x00, tx_active = 0, counters and shreg cleared. This applies mid-RX or mid-TX.
- Input latency: 2 cycles of synchronizer delay. All measured widths are relative to jb_s.
- Command to reply: first reply falling edge occurs exactly TURN_US·CLK_PER_US cycles after the cycle in which cmd_vld is high.
- tx_active rises in the DECODE cycle for a valid reply and falls when TX_STOP completes.
- Frame lengths: poll reply 32·BIT + 2 µs stop; status reply 24·BIT + 2 µs stop.
- The decision threshold is 2 µs, which tolerates ±0.9 µs error on host pulses.
- cmd_vld never asserts for an aborted or truncated frame.

## Configuration
- JOYBUS_DEV_RESET_CMD_EN defined: command 0xFF is answered exactly like 0x00 (reply 0x050002, length 24).
- JOYBUS_DEV_RESET_CMD_EN undefined: 0xFF is handled like any unknown command (cmd_vld pulses, no reply, return to IDLE).

## Test plan
- Poll: host sends 0x01 with btn=16'h8000, stick_x=8'h7F, stick_y=8'h81 -> cmd_vld with cmd=0x01; 50 cycles later the reply 0x80007F81 starts, followed by a 2 µs stop; host decodes btn_A=1.
- Status: host sends 0x00 -> reply 0x050002 (24 bits) plus stop; tx_active is high for the whole reply.
- Unknown command: host sends 0x42 -> cmd_vld with cmd=0x42; JB is never driven; state returns to IDLE.
- Truncated frame: 4 bits, then line high 10 µs -> abort; no cmd_vld; a following 0x01 frame decodes normally.
- Snapshot and reset:
  - btn changes from 16'h8000 to 16'h0000 mid-reply -> remaining bits are unchanged.
  - rst asserted mid-TX -> JB is z on the next cycle and all outputs are 0.
- Macro: host sends 0xFF -> reply 0x050002 with JOYBUS_DEV_RESET_CMD_EN defined; no reply without it.
